// File: rtl/if_id_pipeline_reg.sv
// IF/ID pipeline register: holds fetched instruction and PC+4, splits the held word into
// decode fields, and counts honoured stall cycles with a saturating counter.
module if_id_pipeline_reg #(
  parameter int unsigned    DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int unsigned    CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              instr_valid_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic              valid_o,
  output logic [5:0]        opcode_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        shamt_o,
  output logic [5:0]        funct_o,
  output logic [15:0]       imm_o,
  output logic              ext_en_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_o     <= NOP_INSTR;
      pc_plus4_o  <= '0;
      valid_o     <= 1'b0;
      stall_cnt_o <= '0;
    end else if (flush_i) begin
      // flush wins over stall and does not count as an honoured stall
      instr_o    <= NOP_INSTR;
      pc_plus4_o <= pc_plus4_i;
      valid_o    <= 1'b0;
    end else if (stall_i) begin
      if (stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end else begin
      instr_o    <= instr_valid_i ? instr_i : NOP_INSTR;
      pc_plus4_o <= pc_plus4_i;
      valid_o    <= instr_valid_i;
    end
  end

  assign opcode_o = instr_o[31:26];
  assign rs_o     = instr_o[25:21];
  assign rt_o     = instr_o[20:16];
  assign rd_o     = instr_o[15:11];
  assign shamt_o  = instr_o[10:6];
  assign funct_o  = instr_o[5:0];
  assign imm_o    = instr_o[15:0];

  // andi/ori/xori take a zero-extended immediate; bubbles never request sign extension
  assign ext_en_o = valid_o && !(opcode_o inside {6'h0C, 6'h0D, 6'h0E});

endmodule

// File: tb/tb_if_id_pipeline_reg.sv
// Bench for if_id_pipeline_reg: directed scenarios followed by random stimulus, all checked
// against a behavioural model; a second instance with a 4-bit counter exercises saturation.
module tb_if_id_pipeline_reg;

  logic        clk = 1'b0;
  logic        rst_n, stall_i, flush_i, instr_valid_i;
  logic [31:0] instr_i, pc_plus4_i;

  logic [31:0] instr_o, pc_plus4_o;
  logic        valid_o, ext_en_o;
  logic [5:0]  opcode_o, funct_o;
  logic [4:0]  rs_o, rt_o, rd_o, shamt_o;
  logic [15:0] imm_o, stall_cnt_o;

  logic [31:0] s_instr_o, s_pc_plus4_o;
  logic        s_valid_o, s_ext_en_o;
  logic [5:0]  s_opcode_o, s_funct_o;
  logic [4:0]  s_rs_o, s_rt_o, s_rd_o, s_shamt_o;
  logic [15:0] s_imm_o;
  logic [3:0]  s_stall_cnt_o;

  int checks = 0;
  int failures = 0;

  // reference state
  logic [31:0] m_instr, m_pc;
  logic        m_valid;
  int          m_cnt16, m_cnt4;

  always #5 clk = ~clk;

  if_id_pipeline_reg dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_i(instr_i), .pc_plus4_i(pc_plus4_i),
    .instr_o(instr_o), .pc_plus4_o(pc_plus4_o), .valid_o(valid_o),
    .opcode_o(opcode_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .shamt_o(shamt_o),
    .funct_o(funct_o), .imm_o(imm_o), .ext_en_o(ext_en_o), .stall_cnt_o(stall_cnt_o)
  );

  if_id_pipeline_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_i(instr_i), .pc_plus4_i(pc_plus4_i),
    .instr_o(s_instr_o), .pc_plus4_o(s_pc_plus4_o), .valid_o(s_valid_o),
    .opcode_o(s_opcode_o), .rs_o(s_rs_o), .rt_o(s_rt_o), .rd_o(s_rd_o), .shamt_o(s_shamt_o),
    .funct_o(s_funct_o), .imm_o(s_imm_o), .ext_en_o(s_ext_en_o), .stall_cnt_o(s_stall_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_ext_en();
    int op = int'(m_instr / 32'h0400_0000);
    return m_valid && !(op == 12 || op == 13 || op == 14);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".instr"},  64'(instr_o),    64'(m_instr));
    check({tag, ".pc"},     64'(pc_plus4_o), 64'(m_pc));
    check({tag, ".valid"},  64'(valid_o),    64'(m_valid));
    check({tag, ".opcode"}, 64'(opcode_o),   64'((m_instr / 32'h0400_0000) % 64));
    check({tag, ".rs"},     64'(rs_o),       64'((m_instr / 32'h0020_0000) % 32));
    check({tag, ".rt"},     64'(rt_o),       64'((m_instr / 32'h0001_0000) % 32));
    check({tag, ".rd"},     64'(rd_o),       64'((m_instr / 32'h0000_0800) % 32));
    check({tag, ".shamt"},  64'(shamt_o),    64'((m_instr / 32'h0000_0040) % 32));
    check({tag, ".funct"},  64'(funct_o),    64'(m_instr % 64));
    check({tag, ".imm"},    64'(imm_o),      64'(m_instr % 65536));
    check({tag, ".ext_en"}, 64'(ext_en_o),   64'(exp_ext_en()));
    check({tag, ".cnt16"},  64'(stall_cnt_o), 64'(m_cnt16));
    check({tag, ".s_instr"}, 64'(s_instr_o), 64'(m_instr));
    check({tag, ".s_ext"},  64'(s_ext_en_o), 64'(exp_ext_en()));
    check({tag, ".cnt4"},   64'(s_stall_cnt_o), 64'(m_cnt4));
  endtask

  // one clock: update the model from the inputs seen at the edge, then compare
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      m_instr = '0; m_pc = '0; m_valid = 1'b0; m_cnt16 = 0; m_cnt4 = 0;
    end else if (flush_i) begin
      m_instr = '0; m_pc = pc_plus4_i; m_valid = 1'b0;
    end else if (stall_i) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end else begin
      m_instr = instr_valid_i ? instr_i : 32'h0;
      m_pc    = pc_plus4_i;
      m_valid = instr_valid_i;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic [31:0] ins, input logic [31:0] pc);
    rst_n = r; stall_i = s; flush_i = f; instr_valid_i = v; instr_i = ins; pc_plus4_i = pc;
  endtask

  initial begin
    m_instr = '0; m_pc = '0; m_valid = 1'b0; m_cnt16 = 0; m_cnt4 = 0;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234);
    step("rst0");
    step("rst1");
    check("rst.instr_const", 64'(instr_o), 64'h0);
    check("rst.ext_const", 64'(ext_en_o), 64'h0);

    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h2008ABCD, 32'h4);
    step("addi");
    check("addi.imm_const", 64'(imm_o), 64'hABCD);
    check("addi.rt_const", 64'(rt_o), 64'd8);
    check("addi.ext_const", 64'(ext_en_o), 64'd1);

    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h3509FFFF, 32'h8);
    step("ori");
    check("ori.ext_const", 64'(ext_en_o), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h8D2A0123, 32'hC);
    step("lw");

    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
      step("stall");
    end
    check("stall.held_const", 64'(instr_o), 64'h8D2A0123);
    check("stall.cnt_const", 64'(stall_cnt_o), 64'd3);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h3C01_1234, 32'h10);
    step("release");

    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h2008_0001, 32'h14);
    step("stall_flush");
    check("stall_flush.cnt_const", 64'(stall_cnt_o), 64'd3);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("rst_sat");
    for (int unsigned i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
      step("sat");
    end
    check("sat.cnt4_const", 64'(s_stall_cnt_o), 64'hF);
    check("sat.cnt16_const", 64'(stall_cnt_o), 64'd20);

    for (int unsigned i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 3) != 0), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0)
        instr_i = {$urandom_range(12, 14) == 13 ? 6'h0D : 6'($urandom_range(12, 14)), 26'($urandom)};
      step("rand");
      // outputs must not follow instr_i between edges
      instr_i = ~instr_i;
      #1;
      check("rand.no_comb_path", 64'(instr_o), 64'(m_instr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
